// File: rtl/usb_sie_tx.sv
// usb_sie_tx - full-speed USB transmit serialiser.
// Takes packet bytes from the protocol engine over a valid/ready handshake.
// Each packet goes out as SYNC, then data bits LSB first with bit stuffing,
// NRZI encoded, then EOP. The block drives the transceiver D+/D- pins and
// their output enable.
//
// Ports:
//   clk        system clock (CLK_PER_BIT clocks per USB bit)
//   rst        asynchronous active-low reset
//   tx_data    byte from the PE, latched on the tx_ready cycle
//   tx_valid   PE has a byte; low at a byte boundary ends the packet
//   tx_ready   one-cycle pulse, tx_data latched at the end of this cycle
//   tx_active  high from SYNC start until EOP completes
//   dp_tx      D+ drive value
//   dn_tx      D- drive value
//   tx_oe      transceiver output enable
//
// state | meaning
// IDLE  | line at J, outputs disabled, waiting for tx_valid
// SYNC  | sending KJKJKJKK
// DATA  | sending stuffed NRZI data bits, byte by byte
// EOP   | two SE0 slots then one J slot
module usb_sie_tx #(
    parameter int CLK_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_active,
    output logic       dp_tx,
    output logic       dn_tx,
    output logic       tx_oe
);
    localparam int DW = $clog2(CLK_PER_BIT);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_PER_BIT - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_PER_BIT - 2);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} state_t;

    state_t        state_q;
    logic [DW-1:0] div_q;
    logic [2:0]    idx_q;
    logic [2:0]    ones_q;
    logic [7:0]    shift_q;
    logic [1:0]    eop_q;
    logic          line_q;
    logic          ready_q;
    logic          active_q;
    logic          oe_q;
    logic          dp_q;
    logic          dn_q;

    logic          slot_end;
    logic          stuff_due;
    logic          at_boundary;
    logic          next_bit_d;
    logic          line_d;
    logic [2:0]    ones_d;

    assign slot_end  = (div_q == DIV_LAST);
    assign stuff_due = (ones_q == 3'd6);
    // A byte boundary is reached after the last SYNC bit, or after data bit 7
    // once any stuff bit it owes has been sent.
    assign at_boundary = ((state_q == SYNC) && (idx_q == 3'd7)) ||
                         ((state_q == DATA) && (idx_q == 3'd7) && !stuff_due);

    // Logical bit carried by the slot that starts at the next slot boundary.
    // In IDLE this is the first SYNC bit (0).
    always_comb begin
        next_bit_d = 1'b0;
        unique case (state_q)
            SYNC:    next_bit_d = at_boundary ? tx_data[0] : (idx_q == 3'd6);
            DATA:    next_bit_d = stuff_due ? 1'b0 :
                                  (at_boundary ? tx_data[0] : shift_q[1]);
            default: next_bit_d = 1'b0;
        endcase
        line_d = next_bit_d ? line_q : ~line_q;
        ones_d = next_bit_d ? (ones_q + 3'd1) : 3'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            idx_q    <= 3'd0;
            ones_q   <= 3'd0;
            shift_q  <= 8'h00;
            eop_q    <= 2'd0;
            line_q   <= 1'b1;
            ready_q  <= 1'b0;
            active_q <= 1'b0;
            oe_q     <= 1'b0;
            dp_q     <= 1'b1;
            dn_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    div_q <= '0;
                    if (tx_valid) begin
                        state_q  <= SYNC;
                        idx_q    <= 3'd0;
                        ones_q   <= ones_d;
                        line_q   <= line_d;
                        dp_q     <= line_d;
                        dn_q     <= ~line_d;
                        oe_q     <= 1'b1;
                        active_q <= 1'b1;
                    end
                end
                SYNC, DATA: begin
                    div_q <= slot_end ? '0 : div_q + 1'b1;
                    // tx_ready is decided one clock early so it is registered
                    // and high in the final cycle of the boundary slot.
                    if ((div_q == DIV_PRE) && at_boundary && tx_valid) begin
                        ready_q <= 1'b1;
                    end
                    if (slot_end) begin
                        if (at_boundary && !ready_q) begin
                            state_q <= EOP;
                            eop_q   <= 2'd0;
                            dp_q    <= 1'b0;
                            dn_q    <= 1'b0;
                        end else begin
                            line_q <= line_d;
                            dp_q   <= line_d;
                            dn_q   <= ~line_d;
                            ones_q <= ones_d;
                            if (at_boundary) begin
                                state_q <= DATA;
                                shift_q <= tx_data;
                                idx_q   <= 3'd0;
                            end else if (state_q == SYNC) begin
                                idx_q <= idx_q + 3'd1;
                            end else if (!stuff_due) begin
                                shift_q <= shift_q >> 1;
                                idx_q   <= idx_q + 3'd1;
                            end
                        end
                    end
                end
                EOP: begin
                    div_q <= slot_end ? '0 : div_q + 1'b1;
                    if (slot_end) begin
                        if (eop_q == 2'd2) begin
                            state_q  <= IDLE;
                            oe_q     <= 1'b0;
                            active_q <= 1'b0;
                            line_q   <= 1'b1;
                            ones_q   <= 3'd0;
                            idx_q    <= 3'd0;
                        end else begin
                            eop_q <= eop_q + 2'd1;
                            if (eop_q == 2'd1) begin
                                dp_q <= 1'b1;
                                dn_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready  = ready_q;
    assign tx_active = active_q;
    assign tx_oe     = oe_q;
    assign dp_tx     = dp_q;
    assign dn_tx     = dn_q;
endmodule

// File: tb/tb_usb_sie_tx.sv
module tb_usb_sie_tx;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_active;
    logic       dp_tx;
    logic       dn_tx;
    logic       tx_oe;

    usb_sie_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_active (tx_active),
        .dp_tx     (dp_tx),
        .dn_tx     (dn_tx),
        .tx_oe     (tx_oe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- line monitor / reference decoder ----------------
    logic [1:0] sym_q[$];
    int         rdy_q[$];
    logic [7:0] rx_q[$];
    int         pkts_done = 0;
    int         oe_len    = 0;
    int         gap       = 0;
    int         last_gap  = 0;
    int         pc        = 0;
    bit         in_pkt    = 0;
    bit         line_err  = 0;
    bit         se0_seen  = 0;
    logic       prev_lv;
    int         ones;
    int         nbits;
    logic [7:0] sh;
    logic [1:0] cur;
    logic       bitv;

    always @(negedge clk) begin
        if (!rst) begin
            in_pkt = 0;
        end else if (tx_oe) begin
            if (!in_pkt) begin
                in_pkt   = 1;
                pc       = 0;
                last_gap = gap;
                sym_q.delete();
                rdy_q.delete();
                line_err = 0;
                se0_seen = 0;
                prev_lv  = 1'b1;
                ones     = 0;
                nbits    = 0;
                sh       = 8'h00;
            end
            pc++;
            cur = {dp_tx, dn_tx};
            if (cur == 2'b11 || tx_active !== tx_oe) line_err = 1;
            if ((pc - 1) % CPB == 0) begin
                sym_q.push_back(cur);
                if (cur == 2'b00) begin
                    se0_seen = 1;
                end else if (!se0_seen) begin
                    bitv    = (cur[1] == prev_lv);
                    prev_lv = cur[1];
                    if (ones == 6) begin
                        if (bitv) line_err = 1;
                        ones = 0;
                    end else begin
                        ones = bitv ? ones + 1 : 0;
                        if (sym_q.size() > 8) begin
                            sh = {bitv, sh[7:1]};
                            nbits++;
                            if (nbits == 8) begin
                                rx_q.push_back(sh);
                                nbits = 0;
                            end
                        end
                    end
                end
            end else if (cur != sym_q[$]) begin
                line_err = 1;
            end
            if (tx_ready) rdy_q.push_back(pc);
        end else begin
            if (in_pkt) begin
                in_pkt = 0;
                oe_len = pc;
                pkts_done++;
                gap = 1;
            end else begin
                gap++;
            end
        end
    end

    // ---------------- PE-style byte holder ----------------
    logic [7:0] tx_q[$];

    task automatic drive_pkt(input bit chain, input logic [7:0] nxt);
        int idx        = 0;
        int start_done = pkts_done;
        bit fin        = 0;
        bit last_sent  = 0;
        for (int g = 0; g < 3000 && !fin; g++) begin
            @(negedge clk);
            if (pkts_done != start_done) begin
                fin = 1;
            end else if (tx_ready) begin
                idx++;
                @(posedge clk);
                #1;
                if (idx < tx_q.size()) tx_data = tx_q[idx];
                else begin
                    tx_valid  = 1'b0;
                    last_sent = 1;
                end
            end else if (chain && last_sent && tx_oe && !dp_tx && !dn_tx) begin
                tx_valid = 1'b1;
                tx_data  = nxt;
            end
        end
        check("pkt_done", fin, 1);
    endtask

    function automatic logic [15:0] sync_word();
        logic [15:0] w = 16'h0000;
        for (int i = 0; i < 8 && i < sym_q.size(); i++) w = {w[13:0], sym_q[i]};
        return w;
    endfunction

    function automatic logic [5:0] eop_word();
        int n = sym_q.size();
        if (n < 3) return 6'h3F;
        return {sym_q[n-3], sym_q[n-2], sym_q[n-1]};
    endfunction

    typedef struct {
        int          nb;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          nsym;
        int          rdy0;
        int          rdy1;
        int          nlev;
        logic [31:0] lev;   // data-slot levels, first slot in bit nlev-1, 1=J
    } vec_t;

    vec_t vecs[5];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  all_q[$];
        logic [31:0] lv;
        int          bad;
        int          pd;
        int          oe_seen;

        vecs[0] = '{1, 8'h2D, 8'h00, 19, 32,  0,  8, 32'b01110010};
        vecs[1] = '{2, 8'hFF, 8'h01, 28, 32, 68, 17, 32'b00000111110101010};
        vecs[2] = '{2, 8'h80, 8'h1F, 28, 32, 64, 17, 32'b10101011111110101};
        vecs[3] = '{1, 8'hFC, 8'h00, 20, 32,  0,  9, 32'b100000001};
        vecs[4] = '{2, 8'hFC, 8'h00, 28, 32, 68, 17, 32'b10000000101010101};

        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  tx_ready,  0);
        check("rst_active", tx_active, 0);
        check("rst_oe",     tx_oe,     0);
        check("rst_dp",     dp_tx,     1);
        check("rst_dn",     dn_tx,     0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            tx_q.delete();
            rx_q.delete();
            tx_q.push_back(vecs[v].b0);
            if (vecs[v].nb > 1) tx_q.push_back(vecs[v].b1);
            tx_data  = tx_q[0];
            tx_valid = 1'b1;
            drive_pkt(0, 8'h00);
            check($sformatf("v%0d_oe_len", v), oe_len, vecs[v].nsym * CPB);
            check($sformatf("v%0d_nslots", v), sym_q.size(), vecs[v].nsym);
            check($sformatf("v%0d_sync", v), sync_word(), 16'h6665);
            check($sformatf("v%0d_eop", v), eop_word(), 6'h02);
            check($sformatf("v%0d_ready_cnt", v), rdy_q.size(), vecs[v].nb);
            if (rdy_q.size() > 0) check($sformatf("v%0d_ready0", v), rdy_q[0], vecs[v].rdy0);
            if (vecs[v].nb > 1 && rdy_q.size() > 1)
                check($sformatf("v%0d_ready1", v), rdy_q[1], vecs[v].rdy1);
            lv  = vecs[v].lev;
            bad = 0;
            for (int k = 0; k < vecs[v].nlev; k++) begin
                if (8 + k >= sym_q.size()) bad++;
                else if (sym_q[8+k] != (lv[vecs[v].nlev-1-k] ? 2'b10 : 2'b01)) bad++;
            end
            check($sformatf("v%0d_level_errs", v), bad, 0);
            check($sformatf("v%0d_line_err", v), line_err, 0);
            check($sformatf("v%0d_rx_cnt", v), rx_q.size(), vecs[v].nb);
            for (int k = 0; k < vecs[v].nb && k < rx_q.size(); k++)
                check($sformatf("v%0d_rx%0d", v, k), rx_q[k], tx_q[k]);
            repeat (3) @(posedge clk);
            #1;
        end

        // zero-length packet: tx_valid pulses for one clock
        pd       = pkts_done;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        for (int g = 0; g < 300 && pkts_done == pd; g++) @(negedge clk);
        check("zlp_done", pkts_done - pd, 1);
        check("zlp_oe_len", oe_len, 11 * CPB);
        check("zlp_ready_cnt", rdy_q.size(), 0);
        check("zlp_sync", sync_word(), 16'h6665);
        check("zlp_eop", eop_word(), 6'h02);
        repeat (3) @(posedge clk);
        #1;

        // back-to-back random packets, tx_valid raised again during EOP
        for (int i = 0; i < 64; i++) all_q.push_back(8'($urandom_range(0, 255)));
        rx_q.delete();
        for (int p = 0; p < 4; p++) begin
            tx_q.delete();
            for (int i = 0; i < 16; i++) tx_q.push_back(all_q[p*16 + i]);
            if (p == 0) begin
                tx_data  = tx_q[0];
                tx_valid = 1'b1;
            end
            drive_pkt(p < 3, (p < 3) ? all_q[(p+1)*16] : 8'h00);
            if (p > 0) check($sformatf("b2b%0d_gap", p), last_gap, 1);
            check($sformatf("b2b%0d_line_err", p), line_err, 0);
            check($sformatf("b2b%0d_ready_cnt", p), rdy_q.size(), 16);
        end
        check("b2b_rx_cnt", rx_q.size(), 64);
        bad = 0;
        for (int i = 0; i < 64; i++) if (i >= rx_q.size() || rx_q[i] !== all_q[i]) bad++;
        check("b2b_rx_errs", bad, 0);
        repeat (3) @(posedge clk);
        #1;

        // reset in the middle of a data byte
        tx_q.delete();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h3C);
        tx_data  = tx_q[0];
        tx_valid = 1'b1;
        for (int g = 0; g < 50; g++) begin
            @(negedge clk);
            if (tx_ready) begin
                @(posedge clk);
                #1;
                tx_data = tx_q[1];
            end
        end
        @(negedge clk);
        check("mid_oe_before", tx_oe, 1);
        pd = pkts_done;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_ready",  tx_ready,  0);
        check("mid_rst_active", tx_active, 0);
        check("mid_rst_oe",     tx_oe,     0);
        check("mid_rst_dp",     dp_tx,     1);
        check("mid_rst_dn",     dn_tx,     0);
        tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b1;
        oe_seen = 0;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (tx_oe || !dp_tx || dn_tx) oe_seen++;
        end
        check("mid_rst_no_eop", oe_seen, 0);
        check("mid_rst_no_pkt", pkts_done - pd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
